// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed instruction memory with a loader write port,
// programmable wait-state latency, redirect flush and misaligned/out-of-range fault flagging.
module instr_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_instr,
  output logic [31:0]           resp_addr,
  output logic                  resp_fault,
  input  logic                  resp_ready,
  output logic                  fetch_stall,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [31:0]           mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           rd_word;
  logic                  req_fault;
  logic                  accept;
  logic [31:0]           held_word;
  logic [31:0]           held_addr;
  logic                  held_fault;

  // The index only spans the word-address bits, so a faulting address never reads outside the array.
  assign req_idx   = req_addr[ADDR_WIDTH+1:2];
  assign rd_word   = mem[req_idx];
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);

  assign req_ready   = !flush && ((state == IDLE) || ((state == RESP) && resp_ready));
  assign accept      = req_valid && req_ready;
  assign fetch_stall = (state == WAIT) ||
                       ((state == IDLE) && req_valid && !flush) ||
                       ((state == RESP) && !resp_ready);

  // Loader port; non-blocking write keeps a same-edge read returning the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      held_word  <= rd_word;
      held_addr  <= req_addr;
      held_fault <= req_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_instr <= 32'd0;
      resp_addr  <= 32'd0;
      resp_fault <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_instr <= 32'd0;
      resp_addr  <= 32'd0;
      resp_fault <= 1'b0;
    end else if (accept) begin
      if (LATENCY == 0) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_instr <= req_fault ? 32'd0 : rd_word;
        resp_addr  <= req_addr;
        resp_fault <= req_fault;
      end else begin
        state      <= WAIT;
        cnt        <= LAT;
        resp_valid <= 1'b0;
      end
    end else begin
      case (state)
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_instr <= held_fault ? 32'd0 : held_word;
            resp_addr  <= held_addr;
            resp_fault <= held_fault;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: a LATENCY=2 instance for most scenarios and a LATENCY=0
// instance for back-to-back streaming; expected responses travel through a scoreboard queue.
module tb_instr_mem_responder;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_valid_b = 1'b0;
  logic [31:0] req_addr_b = 32'd0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b1;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = 10'd0;
  logic [31:0] wr_data = 32'd0;

  logic        a_req_ready, a_resp_valid, a_resp_fault, a_fetch_stall;
  logic [31:0] a_resp_instr, a_resp_addr;
  logic        b_req_ready, b_resp_valid, b_resp_fault, b_fetch_stall;
  logic [31:0] b_resp_instr, b_resp_addr;

  logic [31:0] model [0:1023];
  exp_t        sb [$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(a_req_ready),
    .flush(flush), .resp_valid(a_resp_valid), .resp_instr(a_resp_instr), .resp_addr(a_resp_addr),
    .resp_fault(a_resp_fault), .resp_ready(resp_ready), .fetch_stall(a_fetch_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instr_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_addr(req_addr_b), .req_ready(b_req_ready),
    .flush(flush), .resp_valid(b_resp_valid), .resp_instr(b_resp_instr), .resp_addr(b_resp_addr),
    .resp_fault(b_resp_fault), .resp_ready(resp_ready), .fetch_stall(b_fetch_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  function automatic exp_t mk_exp(input logic [31:0] addr);
    exp_t e;
    e.fault = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
    e.instr = e.fault ? 32'd0 : model[addr[11:2]];
    e.addr  = addr;
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = idx; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model[idx] = data;
  endtask

  // Presents one request to instance A, pushes its expected response once the handshake is seen.
  task automatic issue_a(input logic [31:0] addr);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_req_ready) break;
    end
    sb.push_back(mk_exp(addr));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp_a(output logic got, output int cycles, output int stalls);
    got = 1'b0; cycles = 0; stalls = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (a_resp_valid) got = 1'b1;
      else if (a_fetch_stall) stalls++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a_resp_valid, a_resp_fault, a_resp_instr, a_resp_addr} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b fault=%b instr=%h addr=%h, expected all zero",
               a_resp_valid, a_resp_fault, a_resp_instr, a_resp_addr);
    end
    vectors++;
    if (a_req_ready !== 1'b1 || a_fetch_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got req_ready=%b fetch_stall=%b, expected 1/0", a_req_ready, a_fetch_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] addrs [3];
    logic got; int cycles, stalls; exp_t e;
    addrs[0] = 32'h0; addrs[1] = 32'h8; addrs[2] = 32'hC;
    for (int k = 0; k < 3; k++) begin
      issue_a(addrs[k]);
      wait_resp_a(got, cycles, stalls);
      vectors++;
      if (!got || cycles != 3 || stalls != 2) begin
        miscompares++;
        $display("FAIL basic_latency[%0d]: got valid=%b cycles=%0d stalls=%0d, expected 1/3/2", k, got, cycles, stalls);
      end
      e = pop_exp();
      vectors++;
      if (a_resp_instr !== e.instr || a_resp_addr !== e.addr || a_resp_fault !== e.fault) begin
        miscompares++;
        $display("FAIL basic_resp[%0d]: got instr=%h addr=%h fault=%b, expected instr=%h addr=%h fault=%b",
                 k, a_resp_instr, a_resp_addr, a_resp_fault, e.instr, e.addr, e.fault);
      end
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    logic got; int cycles, stalls; exp_t e;
    addrs[0] = 32'h6; addrs[1] = 32'h0000_1000; addrs[2] = 32'hFFFF_FFFC;
    for (int k = 0; k < 3; k++) begin
      issue_a(addrs[k]);
      wait_resp_a(got, cycles, stalls);
      vectors++;
      if (!got || cycles != 3) begin
        miscompares++;
        $display("FAIL fault_latency[%0d]: got valid=%b cycles=%0d, expected 1/3", k, got, cycles);
      end
      e = pop_exp();
      vectors++;
      if (a_resp_instr !== 32'd0 || a_resp_fault !== 1'b1 || a_resp_addr !== e.addr) begin
        miscompares++;
        $display("FAIL fault_resp[%0d]: got instr=%h addr=%h fault=%b, expected instr=0 addr=%h fault=1",
                 k, a_resp_instr, a_resp_addr, a_resp_fault, e.addr);
      end
    end
  endtask

  task automatic test_flush();
    logic seen; logic got; int cycles, stalls; exp_t e;
    // Cancel an accepted fetch while it is waiting.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h8;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_wait_ready: got req_ready=%b, expected 0", a_req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_resp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || a_fetch_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_wait_cancel: got resp_seen=%b fetch_stall=%b, expected 0/0", seen, a_fetch_stall);
    end
    // A request coinciding with flush in IDLE is refused.
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    @(negedge clk);
    vectors++;
    if (a_req_ready !== 1'b0 || a_fetch_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_ready: got req_ready=%b fetch_stall=%b, expected 0/0", a_req_ready, a_fetch_stall);
    end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_resp_valid !== 1'b0 || a_fetch_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_noaccept: got resp_valid=%b fetch_stall=%b, expected 0/0", a_resp_valid, a_fetch_stall);
    end
    issue_a(32'hC);
    wait_resp_a(got, cycles, stalls);
    e = pop_exp();
    vectors++;
    if (!got || a_resp_instr !== 32'h00000013 || a_resp_instr !== e.instr || a_resp_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL flush_next_fetch: got valid=%b instr=%h addr=%h, expected 1 instr=00000013 addr=0000000c",
               got, a_resp_instr, a_resp_addr);
    end
  endtask

  task automatic test_backpressure();
    logic got; int cycles, stalls; exp_t e; logic [31:0] hold_i, hold_a;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue_a(32'h4);
    wait_resp_a(got, cycles, stalls);
    e = pop_exp();
    vectors++;
    if (!got || a_resp_instr !== e.instr || a_resp_addr !== e.addr) begin
      miscompares++;
      $display("FAIL bp_resp: got valid=%b instr=%h addr=%h, expected 1 instr=%h addr=%h",
               got, a_resp_instr, a_resp_addr, e.instr, e.addr);
    end
    hold_i = e.instr; hold_a = e.addr;
    req_valid = 1'b1; req_addr = 32'h8;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (a_resp_valid !== 1'b1 || a_resp_instr !== hold_i || a_resp_addr !== hold_a ||
          a_req_ready !== 1'b0 || a_fetch_stall !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b instr=%h addr=%h ready=%b stall=%b, expected 1 %h %h 0 1",
                 c, a_resp_valid, a_resp_instr, a_resp_addr, a_req_ready, a_fetch_stall, hold_i, hold_a);
      end
    end
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_resp_valid, a_resp_fault, a_resp_instr, a_resp_addr} !== 66'd0) begin
      miscompares++;
      $display("FAIL bp_flush_clear: got valid=%b fault=%b instr=%h addr=%h, expected all zero",
               a_resp_valid, a_resp_fault, a_resp_instr, a_resp_addr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1;
    req_valid_b = 1'b1; req_addr_b = 32'h4;
    @(negedge clk);
    if (b_req_ready) sb.push_back(mk_exp(32'h4));
    @(posedge clk); #1;
    req_addr_b = 32'h8;
    @(negedge clk);
    e = pop_exp();
    vectors++;
    if (b_resp_valid !== 1'b1 || b_resp_instr !== e.instr || b_resp_addr !== e.addr || b_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got valid=%b instr=%h addr=%h ready=%b, expected 1 %h %h 1",
               b_resp_valid, b_resp_instr, b_resp_addr, b_req_ready, e.instr, e.addr);
    end
    if (b_req_ready) sb.push_back(mk_exp(32'h8));
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(negedge clk);
    e = pop_exp();
    vectors++;
    if (b_resp_valid !== 1'b1 || b_resp_instr !== 32'h002081B3 || b_resp_instr !== e.instr || b_resp_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL b2b_second: got valid=%b instr=%h addr=%h, expected 1 002081b3 00000008",
               b_resp_valid, b_resp_instr, b_resp_addr);
    end
    @(negedge clk);
    vectors++;
    if (b_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got resp_valid=%b, expected 0", b_resp_valid);
    end
  endtask

  task automatic test_rw_collision();
    logic got; int cycles, stalls; exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h4;
    wr_en = 1'b1; wr_addr = 10'd1; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    if (a_req_ready) sb.push_back(mk_exp(32'h4));
    @(posedge clk); #1;
    req_valid = 1'b0; wr_en = 1'b0;
    model[1] = 32'hDEADBEEF;
    wait_resp_a(got, cycles, stalls);
    e = pop_exp();
    vectors++;
    if (!got || a_resp_instr !== 32'h00A00113 || a_resp_instr !== e.instr) begin
      miscompares++;
      $display("FAIL rw_old_data: got valid=%b instr=%h, expected 1 00a00113", got, a_resp_instr);
    end
    issue_a(32'h4);
    wait_resp_a(got, cycles, stalls);
    e = pop_exp();
    vectors++;
    if (!got || a_resp_instr !== 32'hDEADBEEF || a_resp_instr !== e.instr) begin
      miscompares++;
      $display("FAIL rw_new_data: got valid=%b instr=%h, expected 1 deadbeef", got, a_resp_instr);
    end
  endtask

  task automatic test_reset_mid();
    logic got, seen; int cycles, stalls; exp_t e;
    issue_a(32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    e = pop_exp();
    vectors++;
    if (a_resp_valid !== 1'b0 || a_fetch_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_wait: got resp_valid=%b fetch_stall=%b, expected 0/0", a_resp_valid, a_fetch_stall);
    end
    @(posedge clk); #1;
    rst = 1'b0; resp_ready = 1'b0;
    issue_a(32'h8);
    wait_resp_a(got, cycles, stalls);
    e = pop_exp();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (!got || {a_resp_valid, a_resp_fault, a_resp_instr, a_resp_addr} !== 66'd0) begin
      miscompares++;
      $display("FAIL rst_mid_resp: got reached=%b valid=%b fault=%b instr=%h addr=%h, expected 1 then all zero",
               got, a_resp_valid, a_resp_fault, a_resp_instr, a_resp_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; resp_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_resp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_lost_fetch: got resp_seen=%b, expected 0", seen);
    end
    issue_a(32'h4);
    wait_resp_a(got, cycles, stalls);
    e = pop_exp();
    vectors++;
    if (!got || cycles != 3 || a_resp_instr !== 32'hDEADBEEF || a_resp_instr !== e.instr) begin
      miscompares++;
      $display("FAIL rst_mem_kept: got valid=%b cycles=%0d instr=%h, expected 1 3 deadbeef", got, cycles, a_resp_instr);
    end
  endtask

  initial begin
    test_reset();
    load_word(10'd0, 32'h00500093);
    load_word(10'd1, 32'h00A00113);
    load_word(10'd2, 32'h002081B3);
    load_word(10'd3, 32'h00000013);
    test_basic();
    test_fault();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_rw_collision();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Responder end of the instruction-fetch interface. It accepts PC fetch requests from the fetch stage and returns the 32-bit instruction word from an internal word-addressed instruction memory.
- Supports configurable wait-state latency, flush-cancel on branch/jump redirect, and fault flagging.
- Has a loader write port used to preload programs.
- Drives a stall signal to the hazard unit while a fetch is outstanding.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH words.
LATENCY, 2, wait cycles between request accept and response, legal range 0..15.

Ports:
clk  in  1  clock; all state updates on posedge clk.
rst  in  1  reset; asynchronous and active-high.
req_valid  in  1  fetch request present.
req_addr  in  32  byte address (PC) of the request.
req_ready  out  1  responder can accept a request this cycle.
flush  in  1  cancel any in-flight or pending fetch (redirect).
resp_valid  out  1  response word available.
resp_instr  out  32  fetched instruction; 32'd0 on fault.
resp_addr  out  32  byte address belonging to resp_instr.
resp_fault  out  1  response is for a misaligned or out-of-range address.
resp_ready  in  1  fetch stage consumes the response (IF/ID write enable).
fetch_stall  out  1  fetch stage must hold its PC and IF/ID register.
wr_en  in  1  loader write enable.
wr_addr  in  ADDR_WIDTH  loader word address.
wr_data  in  32  loader write data.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0.
  - resp_valid=0, resp_instr=0, resp_addr=0, resp_fault=0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready) || flush-free back-to-back, i.e. !flush && (IDLE || (RESP && resp_ready)).
- Accept = req_valid && req_ready. On accept:
  - Latch req_addr.
  - Compute fault = (req_addr[1:0]!=0) || (req_addr[31:ADDR_WIDTH+2]!=0).
  - Read mem[req_addr[ADDR_WIDTH+1:2]] into an internal register.
  - Load counter with LATENCY.
- Transitions:
  - IDLE -> WAIT on accept when LATENCY>0.
  - IDLE -> RESP on accept when LATENCY==0.
  - WAIT: counter decrements each cycle; -> RESP on the cycle the counter reaches 1 → 0.
  - RESP: resp_valid=1, and the outputs stay stable until resp_ready.
  - RESP with resp_ready && !accept -> IDLE.
  - RESP with resp_ready && accept -> WAIT or RESP for the new request (back-to-back, no bubble).
- Latency: request accepted at edge N → resp_valid high in the cycle after edge N+LATENCY. With LATENCY=0 the response appears in the cycle following accept.
- Fault response: resp_instr=32'd0 (pipeline bubble), resp_fault=1, same latency as a normal fetch. The memory is not indexed out of range.
- Flush has priority over all other inputs:
  - Next state is IDLE and resp_valid drops at the next edge.
  - Any in-flight word is discarded.
  - A req_valid presented in the flush cycle is not accepted (req_ready=0).
  - resp_instr, resp_addr and resp_fault are cleared to 0.
- fetch_stall (combinational) = (state==WAIT) || (state==IDLE && req_valid && !flush) || (state==RESP && !resp_ready).
  - resp_ready is deasserted exactly when the fetch stage is stalled by downstream hazards.
- Write port:
  - wr_en writes mem[wr_addr] at posedge and is independent of the FSM.
  - If a write and an accepted read hit the same word in the same cycle, the read returns the old data (read-before-write).
- Reset asserted mid-operation: the FSM returns to IDLE immediately and all outputs are cleared asynchronously. The in-flight fetch is lost.

Test Plan:
- Preload mem[0..3]=32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013; LATENCY=2; hold resp_ready=1; req 0x0 → resp_valid in the 3rd cycle after accept with resp_instr=32'h00500093 and resp_addr=0. fetch_stall is high for 2 cycles.
- Back-to-back: with LATENCY=0, present 0x4 then 0x8 on consecutive accepts → responses 32'h00A00113 then 32'h002081B3 on consecutive cycles, with no idle cycle between them.
- Misaligned fetch 0x6 → resp_instr=0 and resp_fault=1 after LATENCY+1 cycles. Out-of-range fetch 0x0000_1000 (ADDR_WIDTH=10) → resp_fault=1.
- Flush during WAIT: accept 0x8, then assert flush the next cycle → resp_valid never rises for 0x8 and state is IDLE. The next req 0xC returns 32'h00000013.
- Backpressure: resp_valid=1 with resp_ready=0 for 3 cycles → resp_instr/resp_addr held constant, req_ready=0, fetch_stall=1.
- Same-cycle write and read of word 1 with wr_data=32'hDEADBEEF → response is the old word 32'h00A00113. A subsequent read of word 1 returns 32'hDEADBEEF. Asserting rst mid-WAIT clears resp_valid immediately.
